keypad_decoder: RTL and testbench
=================================

Name: keypad_decoder

Overview:
- Converts the keyboard scan-code byte stream (PS/2 set 2, from the existing PS/2 byte receiver) into per-key level "IsPressed" signals.
- Those signals feed the flipper controller (key4IsPressed/key6IsPressed) and the game-control logic (launch, restart).
- Tracks make/break/extended prefixes with a small FSM and produces one-cycle press pulses.

Parameters:
TIMEOUT_FRAMES, 30, frames without a make/repeat before a held key is force-released (used only with KEYPAD_TIMEOUT_EN)

Ports:
clk  input  1  system clock
resetN  input  1  asynchronous active-low reset
startOfFrame  input  1  one-cycle pulse per video frame
byteValid  input  1  one-cycle strobe: byteData holds a new received byte
byteData  input  8  received scan-code byte
clearKeys  input  1  synchronous clear of all key state (level restart)
key4IsPressed  output  1  keypad 4 / left arrow held
key6IsPressed  output  1  keypad 6 / right arrow held
key8IsPressed  output  1  keypad 8 / up arrow held
key2IsPressed  output  1  keypad 2 / down arrow held
key5IsPressed  output  1  keypad 5 held
keyEnterIsPressed  output  1  Enter (main or keypad) held
keyPressPulse  output  6  one-cycle rising pulse per key; bit order {Enter,5,2,8,6,4}, bit0 = key4

Behaviour:
- Reset (resetN=0, async): FSM=IDLE, all IsPressed=0, keyPressPulse=0, timeout counters=0.
- FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). Transitions occur only on cycles with byteValid=1.
- 0xE0 from any state -> EXT (restarts the sequence).
- 0xF0: IDLE->BRK, EXT->EXT_BRK; BRK and EXT_BRK stay.
- Any other byte is a code byte. It is decoded with break = (state is BRK or EXT_BRK), then FSM -> IDLE.
- Code map (the extended prefix is ignored for mapping; arrows alias the keypad keys): 0x6B->4, 0x74->6, 0x75->8, 0x72->2, 0x73->5, 0x5A->Enter.
- Unmapped code bytes (including 0xAA, 0xFA, 0xE1, 0x12 fake-shift) change no key state; FSM -> IDLE.
- Make of a mapped key sets its IsPressed on the clock edge after byteValid. Break clears it on the same edge.
- Latency: output registered, 1 cycle after the byteValid of the final code byte.
- keyPressPulse[k] is high for exactly the cycle in which IsPressed[k] goes 0->1.
- Typematic repeat makes (key already pressed) produce no pulse.
- Break of a key not pressed: no effect.
- clearKeys=1: all IsPressed and pulses to 0, counters to 0, FSM -> IDLE. Any byte in that cycle is dropped. clearKeys has priority over byteValid.
- byteValid with byteData=0xF0 followed by 0xE0: treated as a new extended sequence (E0 restart rule). The pending break is discarded.
- Multiple keys may be held simultaneously; each bit is independent.
- startOfFrame has no effect without the optional feature.

Optional Feature:
- Macro: KEYPAD_TIMEOUT_EN.
- Defined:
  - Each key has a counter of width $clog2(TIMEOUT_FRAMES+1).
  - While the key is pressed, the counter increments on each startOfFrame.
  - A make of that key (including a repeat) reloads the counter to 0. If the make and startOfFrame fall in the same cycle, the reload wins.
  - When the counter reaches TIMEOUT_FRAMES, IsPressed is cleared and the counter reset to 0, with no pulse.
  - A break or clearKeys also zeroes the counter.
- Undefined: no counters are built. Keys stay pressed until a break or clearKeys. startOfFrame is unused.

Test Plan:
- Bytes 0x6B, then F0 6B -> key4IsPressed=1 one cycle after the first strobe, keyPressPulse=6'b000001 for 1 cycle; key4IsPressed=0 one cycle after the final 0x6B.
- Bytes E0 74, E0 74, E0 F0 74 -> key6IsPressed=1 after the first 0x74; a single pulse on bit1 (no pulse on the repeat); key6IsPressed=0 after the last 0x74.
- Sequence 6B, 74, 5A held together, then F0 74 -> key4=1, key6=0, Enter=1. Other keys stay 0.
- Bytes F0 E0 6B with key4 held -> treated as extended make: key4 stays 1, no pulse. Then unmapped 0x1C -> no output change, FSM returns to IDLE.
- key5 held, clearKeys=1 in the same cycle as byteValid=0x73 -> key5IsPressed=0, no pulse, byte ignored. Also assert resetN=0 mid-sequence (after E0 F0) -> outputs 0 immediately; next 0x6B is a make.
- KEYPAD_TIMEOUT_EN, TIMEOUT_FRAMES=3: make 0x75 then 3 startOfFrame pulses with no bytes -> key8IsPressed=0 after the 3rd. Repeat 0x75 coinciding with the 2nd frame pulse -> counter reloads; release only after 3 further frames.

Source files
------------

// File: rtl/keypad_decoder.sv
// PS/2 set-2 scan-code stream to per-key held levels and one-cycle press pulses (keypad 4/6/8/2/5, Enter).
// Latency: one cycle from the byteValid of the final code byte to the registered outputs.
// Backpressure: none, every strobed byte is consumed; optional KEYPAD_TIMEOUT_EN adds per-key frame timeouts.
module keypad_decoder #(
  parameter int TIMEOUT_FRAMES = 30
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       byteValid,
  input  logic [7:0] byteData,
  input  logic       clearKeys,
  output logic       key4IsPressed,
  output logic       key6IsPressed,
  output logic       key8IsPressed,
  output logic       key2IsPressed,
  output logic       key5IsPressed,
  output logic       keyEnterIsPressed,
  output logic [5:0] keyPressPulse
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t     state, state_nxt;
  logic [5:0] pressed, pulse;
  logic [5:0] key_hit, make_hit, brk_hit, tmo_hit;
  logic       code_vld, is_brk;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)        state <= IDLE;
    else if (clearKeys) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (byteValid) begin
      case (byteData)
        8'hE0:   state_nxt = EXT;
        8'hF0:   state_nxt = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Extended prefix does not affect mapping, so arrows alias the keypad keys.
  always_comb begin
    key_hit = 6'b0;
    case (byteData)
      8'h6B:   key_hit = 6'b000001;
      8'h74:   key_hit = 6'b000010;
      8'h75:   key_hit = 6'b000100;
      8'h72:   key_hit = 6'b001000;
      8'h73:   key_hit = 6'b010000;
      8'h5A:   key_hit = 6'b100000;
      default: key_hit = 6'b0;
    endcase
    code_vld = byteValid && (byteData != 8'hE0) && (byteData != 8'hF0);
    is_brk   = (state == BRK) || (state == EXT_BRK);
    make_hit = (code_vld && !is_brk) ? key_hit : 6'b0;
    brk_hit  = (code_vld &&  is_brk) ? key_hit : 6'b0;
  end

`ifdef KEYPAD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_FRAMES + 1);

  logic [CW-1:0] cnt [6];

  // Release fires on the frame that would bring the count to TIMEOUT_FRAMES; a make that cycle wins.
  always_comb begin
    for (int k = 0; k < 6; k++)
      tmo_hit[k] = pressed[k] && startOfFrame && !make_hit[k] &&
                   (cnt[k] == CW'(TIMEOUT_FRAMES - 1));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int k = 0; k < 6; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (clearKeys || make_hit[k] || brk_hit[k] || tmo_hit[k])
          cnt[k] <= '0;
        else if (pressed[k] && startOfFrame)
          cnt[k] <= cnt[k] + CW'(1);
      end
    end
  end
`else
  logic unused_sof;
  assign unused_sof = startOfFrame;
  assign tmo_hit    = 6'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pressed <= 6'b0;
      pulse   <= 6'b0;
    end else if (clearKeys) begin
      pressed <= 6'b0;
      pulse   <= 6'b0;
    end else begin
      pressed <= (pressed | make_hit) & ~brk_hit & ~tmo_hit;
      pulse   <= make_hit & ~pressed;
    end
  end

  assign key4IsPressed     = pressed[0];
  assign key6IsPressed     = pressed[1];
  assign key8IsPressed     = pressed[2];
  assign key2IsPressed     = pressed[3];
  assign key5IsPressed     = pressed[4];
  assign keyEnterIsPressed = pressed[5];
  assign keyPressPulse     = pulse;

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed bench for keypad_decoder: vector table plus hand sequences for reset and timeout corners.
module tb_keypad_decoder;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       byteValid = 1'b0;
  logic [7:0] byteData = 8'h00;
  logic       clearKeys = 1'b0;
  logic       key4IsPressed, key6IsPressed, key8IsPressed;
  logic       key2IsPressed, key5IsPressed, keyEnterIsPressed;
  logic [5:0] keyPressPulse;
  logic [5:0] keys;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       clr;
    logic       vld;
    logic [7:0] dat;
    logic [5:0] exp_keys;
    logic [5:0] exp_pulse;
  } vec_t;

  vec_t vq[$];

  keypad_decoder #(.TIMEOUT_FRAMES(3)) dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (startOfFrame),
    .byteValid         (byteValid),
    .byteData          (byteData),
    .clearKeys         (clearKeys),
    .key4IsPressed     (key4IsPressed),
    .key6IsPressed     (key6IsPressed),
    .key8IsPressed     (key8IsPressed),
    .key2IsPressed     (key2IsPressed),
    .key5IsPressed     (key5IsPressed),
    .keyEnterIsPressed (keyEnterIsPressed),
    .keyPressPulse     (keyPressPulse)
  );

  always #5 clk = ~clk;

  assign keys = {keyEnterIsPressed, key5IsPressed, key2IsPressed,
                 key8IsPressed, key6IsPressed, key4IsPressed};

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, sample 1ns after the rising edge.
  task automatic step(input logic clr, input logic vld, input logic [7:0] dat, input logic sof);
    @(negedge clk);
    clearKeys    = clr;
    byteValid    = vld;
    byteData     = dat;
    startOfFrame = sof;
    @(posedge clk);
    #1;
    clearKeys    = 1'b0;
    byteValid    = 1'b0;
    startOfFrame = 1'b0;
  endtask

  task automatic add(input logic clr, input logic vld, input logic [7:0] dat,
                     input logic [5:0] ek, input logic [5:0] ep);
    vec_t v;
    v.clr = clr; v.vld = vld; v.dat = dat; v.exp_keys = ek; v.exp_pulse = ep;
    vq.push_back(v);
  endtask

  initial begin
    // make / break of key4
    add(0, 1, 8'h6B, 6'b000001, 6'b000001);
    add(0, 0, 8'h00, 6'b000001, 6'b000000);
    add(0, 1, 8'hF0, 6'b000001, 6'b000000);
    add(0, 1, 8'h6B, 6'b000000, 6'b000000);
    // extended right arrow with typematic repeat
    add(0, 1, 8'hE0, 6'b000000, 6'b000000);
    add(0, 1, 8'h74, 6'b000010, 6'b000010);
    add(0, 1, 8'hE0, 6'b000010, 6'b000000);
    add(0, 1, 8'h74, 6'b000010, 6'b000000);
    add(0, 1, 8'hE0, 6'b000010, 6'b000000);
    add(0, 1, 8'hF0, 6'b000010, 6'b000000);
    add(0, 1, 8'h74, 6'b000000, 6'b000000);
    // three keys held, release key6
    add(0, 1, 8'h6B, 6'b000001, 6'b000001);
    add(0, 1, 8'h74, 6'b000011, 6'b000010);
    add(0, 1, 8'h5A, 6'b100011, 6'b100000);
    add(0, 1, 8'hF0, 6'b100011, 6'b000000);
    add(0, 1, 8'h74, 6'b100001, 6'b000000);
    // F0 E0 6B restarts as extended make; unmapped 1C returns to IDLE
    add(0, 1, 8'hF0, 6'b100001, 6'b000000);
    add(0, 1, 8'hE0, 6'b100001, 6'b000000);
    add(0, 1, 8'h6B, 6'b100001, 6'b000000);
    add(0, 1, 8'h1C, 6'b100001, 6'b000000);
    add(0, 1, 8'h72, 6'b101001, 6'b001000);
    add(0, 1, 8'hAA, 6'b101001, 6'b000000);
    add(0, 1, 8'hE1, 6'b101001, 6'b000000);
    add(0, 1, 8'h12, 6'b101001, 6'b000000);
    // break of a key not held
    add(0, 1, 8'hF0, 6'b101001, 6'b000000);
    add(0, 1, 8'h75, 6'b101001, 6'b000000);
    add(1, 0, 8'h00, 6'b000000, 6'b000000);
    // clearKeys beats a same-cycle make, and drops a pending break
    add(0, 1, 8'h73, 6'b010000, 6'b010000);
    add(1, 1, 8'h73, 6'b000000, 6'b000000);
    add(0, 0, 8'h00, 6'b000000, 6'b000000);
    add(0, 1, 8'hF0, 6'b000000, 6'b000000);
    add(1, 0, 8'h00, 6'b000000, 6'b000000);
    add(0, 1, 8'h73, 6'b010000, 6'b010000);
    add(0, 0, 8'h00, 6'b010000, 6'b000000);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_keys", keys, 6'b0);
    chk("reset_pulse", keyPressPulse, 6'b0);
    @(negedge clk);
    resetN = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].clr, vq[i].vld, vq[i].dat, 1'b0);
      chk($sformatf("vec%0d_keys", i), keys, vq[i].exp_keys);
      chk($sformatf("vec%0d_pulse", i), keyPressPulse, vq[i].exp_pulse);
    end

    // async reset in the middle of E0 F0, with key5 still held
    step(0, 1, 8'hE0, 0);
    step(0, 1, 8'hF0, 0);
    #2;
    resetN = 1'b0;
    #1;
    chk("async_reset_keys", keys, 6'b0);
    @(negedge clk);
    resetN = 1'b1;
    step(0, 1, 8'h6B, 0);
    chk("post_reset_make_keys", keys, 6'b000001);
    chk("post_reset_make_pulse", keyPressPulse, 6'b000001);
    step(1, 0, 8'h00, 0);
    chk("post_reset_clear", keys, 6'b0);

`ifdef KEYPAD_TIMEOUT_EN
    step(0, 1, 8'h75, 0);
    chk("tmo_make", keys, 6'b000100);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    chk("tmo_after_2", keys, 6'b000100);
    step(0, 0, 8'h00, 1);
    chk("tmo_after_3", keys, 6'b000000);
    chk("tmo_no_pulse", keyPressPulse, 6'b000000);
    step(0, 1, 8'h75, 0);
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'h75, 1);
    chk("tmo_reload_pulse", keyPressPulse, 6'b000000);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    chk("tmo_reload_held", keys, 6'b000100);
    step(0, 0, 8'h00, 1);
    chk("tmo_reload_release", keys, 6'b000000);
`else
    step(0, 1, 8'h75, 0);
    repeat (5) step(0, 0, 8'h00, 1);
    chk("no_tmo_held", keys, 6'b000100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
